wfg_wb_master: RTL and testbench

WFG_WB_MASTER -- requirements
Module: wfg_wb_master

---
 rtl/wfg_wb_master.sv | 155 +++++++++++++++
 tb/tb_wfg_wb_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfg_wb_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
// Define WFG_WB_MASTER_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT cycles.
module wfg_wb_master #(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [BUSW-1:0]   req_adr_i,
  input  logic [BUSW-1:0]   req_dat_i,
  input  logic [BUSW/8-1:0] req_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUSW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  input  logic [BUSW-1:0]   wbm_dat_i,
  input  logic              wbm_ack_i
);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("wfg_wb_master: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_cyc, w_cyc_nxt;
  logic              r_we, w_we_nxt;
  logic [BUSW/8-1:0] r_sel, w_sel_nxt;
  logic [BUSW-1:0]   r_adr, w_adr_nxt;
  logic [BUSW-1:0]   r_wdat, w_wdat_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [BUSW-1:0]   r_rsp_dat, w_rsp_dat_nxt;

`ifdef WFG_WB_MASTER_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT) + 1;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_adr_nxt       = r_adr;
    w_wdat_nxt      = r_wdat;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
    w_rsp_err_nxt   = r_rsp_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_we_nxt    = req_we_i;
          w_adr_nxt   = req_adr_i;
          w_wdat_nxt  = req_dat_i;
          w_sel_nxt   = req_sel_i;
          w_cyc_nxt   = 1'b1;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        // Ack is tested first so a late ack still wins over an expiring timer.
        if (wbm_ack_i) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_dat_nxt   = r_we ? '0 : wbm_dat_i;
          w_rsp_valid_nxt = 1'b1;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
          w_rsp_err_nxt   = 1'b0;
`endif
          w_state_nxt     = S_RESP;
        end
`ifdef WFG_WB_MASTER_TIMEOUT_EN
        else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
          w_cyc_nxt       = 1'b0;
          w_rsp_dat_nxt   = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_wdat      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_adr       <= w_adr_nxt;
      r_wdat      <= w_wdat_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
      r_cnt       <= w_cnt_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
`endif
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_wdat;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
  assign rsp_err_o   = r_rsp_err;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wfg_wb_master.sv
// Bench for wfg_wb_master: directed commands, behavioural Wishbone slave, response scoreboard.
module tb_wfg_wb_master;
  localparam int BUSW    = 32;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_we, rsp_ready;
  logic [31:0]     req_adr, req_dat;
  logic [3:0]      req_sel;
  logic            req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0]     rsp_dat_o;
  logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]      wbm_sel_o;
  logic [31:0]     wbm_adr_o, wbm_dat_o;
  logic [31:0]     wbm_dat_i;
  logic            wbm_ack_i;

  wfg_wb_master #(.BUSW(BUSW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t exp_e;

  // Scoreboard monitor: every completed response handshake is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got dat 0x%08h err %0d, expected no response", rsp_dat_o, rsp_err_o);
      end else begin
        exp_e = exp_q.pop_front();
        chk("rsp_dat", rsp_dat_o, exp_e.dat);
        chk("rsp_err", 32'(rsp_err_o), 32'(exp_e.err));
      end
    end
  end

  // Slave: acks after ack_delay strobed cycles (0 = never), byte-lane writes, registered read data.
  logic [31:0] mem [16];
  int          seen;
  int          ack_delay;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_ack_i <= 1'b0;
      wbm_dat_i <= '0;
      seen      <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
      if (ack_delay != 0 && seen + 1 >= ack_delay) begin
        wbm_ack_i <= 1'b1;
        if (wbm_we_o) begin
          for (int b = 0; b < 4; b++)
            if (wbm_sel_o[b]) mem[wbm_adr_o[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
        end else begin
          wbm_dat_i <= mem[wbm_adr_o[5:2]];
        end
      end
      seen <= seen + 1;
    end else begin
      wbm_ack_i <= 1'b0;
      seen      <= 0;
    end
  end

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) chk("req_ready_wait", 32'(req_ready_o), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] dat, input logic err);
    rsp_t e;
    e.dat = dat;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Starts at the falling edge after acceptance; counts strobed cycles and edges until rsp_valid.
  task automatic run_bus(input int limit, output int cyc_cycles, output int lat);
    cyc_cycles = 0;
    lat        = 0;
    while (!rsp_valid_o && lat < limit) begin
      if (wbm_cyc_o && wbm_stb_o) cyc_cycles++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready_o && !rsp_valid_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_wait", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cc, lat;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    req_adr = '0; req_dat = '0; req_sel = '0; ack_delay = 1;
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_cyc_stb_we", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat_sel", wbm_dat_o | 32'(wbm_sel_o), 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid_o, rsp_err_o} | rsp_dat_o, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-wait write
    push(32'd0, 1'b0);
    issue(1'b1, 32'h8, 32'h0000_1234, 4'hF);
    chk("wr_we", 32'(wbm_we_o), 32'd1);
    chk("wr_adr", wbm_adr_o, 32'h8);
    chk("wr_dat", wbm_dat_o, 32'h0000_1234);
    chk("wr_sel", 32'(wbm_sel_o), 32'hF);
    chk("wr_req_ready_busy", 32'(req_ready_o), 32'd0);
    run_bus(20, cc, lat);
    chk("wr_cyc_cycles", 32'(cc), 32'd2);
    chk("wr_latency", 32'(lat), 32'd2);
    wait_idle();

    // read back
    push(32'h0000_1234, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    chk("rd_we", 32'(wbm_we_o), 32'd0);
    run_bus(20, cc, lat);
    chk("rd_latency", 32'(lat), 32'd2);
    wait_idle();

    // partial byte-select write and read back
    push(32'd0, 1'b0);
    issue(1'b1, 32'h10, 32'hAABB_CCDD, 4'h5);
    run_bus(20, cc, lat);
    wait_idle();
    push(32'h00BB_00DD, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    run_bus(20, cc, lat);
    wait_idle();

    // response back-pressure for 5 cycles, with a competing request held meanwhile
    rsp_ready = 1'b0;
    push(32'h0000_1234, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    run_bus(20, cc, lat);
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h10; req_dat = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_rsp_dat", rsp_dat_o, 32'h0000_1234);
      chk("bp_req_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_no_new_cycle", 32'(wbm_cyc_o), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_post_valid", 32'(rsp_valid_o), 32'd0);
    chk("bp_post_ready", 32'(req_ready_o), 32'd1);
    chk("bp_post_cyc", 32'(wbm_cyc_o), 32'd0);

    // ack arrives on the 16th strobed cycle, coincident with timer expiry
    ack_delay = 15;
    push(32'h0000_1234, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    run_bus(40, cc, lat);
    chk("late_ack_cycles", 32'(cc), 32'd16);
    chk("late_ack_latency", 32'(lat), 32'd16);
    wait_idle();

    // slave never acks
    ack_delay = 0;
`ifdef WFG_WB_MASTER_TIMEOUT_EN
    push(32'd0, 1'b1);
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    run_bus(40, cc, lat);
    chk("to_cycles", 32'(cc), 32'd16);
    chk("to_latency", 32'(lat), 32'd16);
    chk("to_cyc_low", 32'(wbm_cyc_o | wbm_stb_o), 32'd0);
    wait_idle();
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
`else
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    run_bus(100, cc, lat);
    chk("noto_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("noto_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
`endif

    // asynchronous reset in the middle of a bus cycle
    chk("mid_bus_cyc", 32'(wbm_cyc_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("rst_async_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ready", 32'(req_ready_o), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid_o || wbm_cyc_o) chk("rst_no_rsp", {30'd0, rsp_valid_o, wbm_cyc_o}, 32'd0);
    end

    // normal operation resumes
    ack_delay = 1;
    push(32'd0, 1'b0);
    issue(1'b1, 32'h4, 32'h5555_AAAA, 4'hF);
    run_bus(20, cc, lat);
    chk("post_rst_latency", 32'(lat), 32'd2);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
